axi_lite_regfile_sub: RTL and testbench
=======================================

Name: axi_lite_regfile_sub

Overview:
- AXI4-Lite subordinate (responder) holding a bank of NUM_REGS word-wide registers.
- Terminates the master port of the AXI-Lite interconnect and data-width converters, e.g. behind a downsizer.
- Exposes register contents and per-register write strobes to local hardware.
- Out-of-range or read-only accesses complete with SLVERR.

Parameters:
- AXI_ADDR_WIDTH, 32'd8, byte address width; must be ≥ log2(NUM_REGS) + log2(AXI_DATA_WIDTH/8).
- AXI_DATA_WIDTH, 32'd32, data width; one of 8/16/32/64. STRB = AXI_DATA_WIDTH/8.
- NUM_REGS, 32'd8, number of registers, ≥1.
- RO_MASK, '0 (NUM_REGS bits), bit i set = register i is read-only to the bus.
- RESET_VALUE, '0 (AXI_DATA_WIDTH bits), reset value of every register.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- aw_addr_i  in  AXI_ADDR_WIDTH  write address.
- aw_prot_i  in  3  ignored.
- aw_valid_i  in  1;  aw_ready_o  out  1.
- w_data_i  in  AXI_DATA_WIDTH;  w_strb_i  in  STRB.
- w_valid_i  in  1;  w_ready_o  out  1.
- b_resp_o  out  2;  b_valid_o  out  1;  b_ready_i  in  1.
- ar_addr_i  in  AXI_ADDR_WIDTH;  ar_prot_i  in  3 (ignored).
- ar_valid_i  in  1;  ar_ready_o  out  1.
- r_data_o  out  AXI_DATA_WIDTH;  r_resp_o  out  2.
- r_valid_o  out  1;  r_ready_i  in  1.
- reg_q_o  out  NUM_REGS*AXI_DATA_WIDTH  register contents; register i at [i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
- reg_wr_o  out  NUM_REGS  one-cycle pulse, register i written by the bus.

Behaviour:
- Decode: idx = addr[AXI_ADDR_WIDTH-1 : log2(STRB)]. Low byte-offset bits are ignored. idx ≥ NUM_REGS is out of range.
- Responses: OKAY = 2'b00, SLVERR = 2'b10.
- Reset (rst_i high, async):
  - all registers = RESET_VALUE.
  - aw_held = w_held = 0; b_valid_o = r_valid_o = 0.
  - b_resp_o = r_resp_o = 0; r_data_o = 0; reg_wr_o = 0.
  - Readies are derived combinationally from state, so all three are 1 during and after reset.
- Write path, AW and W are independent:
  - aw_ready_o = !aw_held && !b_valid_o. On handshake, latch addr and set aw_held.
  - w_ready_o = !w_held && !b_valid_o. On handshake, latch data/strb and set w_held.
  - Any arrival order is legal: AW first, W first, or same cycle. The held channel's ready stays low until commit.
- Write commit: in the cycle where both are available (held or handshaking now):
  - If in range and not RO: byte lanes with strb=1 are updated at that clock edge and reg_wr_o[idx] pulses for that cycle.
  - strb = 0 on a legal register still responds OKAY and pulses reg_wr_o.
  - Out-of-range or RO: no register change, no pulse, response SLVERR.
  - Next cycle: b_valid_o = 1 with b_resp_o, aw_held = w_held = 0.
- B channel: b_valid_o and b_resp_o hold stable until b_ready_i. They clear on the edge where b_valid_o && b_ready_i. New AW/W are accepted from the following cycle.
- Write latency: same-cycle AW+W handshake in cycle N → register updated and visible on reg_q_o in cycle N+1, b_valid_o in N+1.
- Read path:
  - ar_ready_o = !r_valid_o.
  - On handshake in cycle N: r_valid_o = 1 in N+1, with r_data_o = register value sampled at the end of cycle N and r_resp_o.
  - Out of range → r_data_o = 0, SLVERR. RO registers read normally, OKAY.
  - r_data_o and r_resp_o are held stable until r_ready_i. r_valid_o clears on the edge where r_valid_o && r_ready_i. Throughput is one read per 2 cycles.
- Simultaneous read and write commit to the same register in the same cycle: the read returns the pre-write value.
- Read and write paths operate fully concurrently. There is no ordering between them.
- Reset asserted mid-transaction: all pending AW/W/B/R state is discarded with no response, and registers return to RESET_VALUE.
- No combinational path from any *_valid_i to any *_ready_o.

Test Plan:
- Reset, then same-cycle AW addr 0x04 + W data 0xDEADBEEF, strb 4'hF → reg 1 = 0xDEADBEEF; reg_wr_o = 8'h02 for one cycle; b_valid_o next cycle with OKAY.
- W first (0x11223344, strb 4'b0101), AW addr 0x08 three cycles later; w_ready_o low meanwhile → reg 2 = 0x00220044 from RESET 0; B OKAY.
- Out-of-range AW addr 0x40 (NUM_REGS=8) → no reg change, no reg_wr_o; b_resp_o = 2'b10. Out-of-range read 0x40 → r_data_o = 0, SLVERR.
- RO_MASK = 8'h01: write 0xFFFFFFFF to 0x00 → reg 0 unchanged, SLVERR. Read 0x00 → RESET_VALUE, OKAY.
- Hold b_ready_i/r_ready_i low for 5 cycles → b/r outputs stable; aw/w/ar readies stay low; the next transaction is accepted the cycle after the ready handshake.
- Same-cycle read and write commit to 0x0C (old value 0xA5A5A5A5, new 0x5A5A5A5A) → read returns 0xA5A5A5A5; a subsequent read returns 0x5A5A5A5A. Assert rst_i with b_valid_o pending → b_valid_o drops immediately and reg 3 = RESET_VALUE.

Source files
------------

// File: rtl/axi_lite_regfile_sub.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile_sub
//
// AXI4-Lite subordinate holding NUM_REGS word-wide registers. It sits on the
// master side of an AXI-Lite interconnect or width converter and exposes the
// register contents and per-register write pulses to local hardware.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   aw_* / w_* / b_*        write address, write data, write response channels
//   ar_* / r_*              read address and read data channels
//   reg_q_o                 register contents, register i at [i*DW +: DW]
//   reg_wr_o                one-cycle pulse per register written by the bus,
//                           aligned with the cycle the new value appears
//
// Responses are OKAY (2'b00) or SLVERR (2'b10). Out-of-range writes and writes
// to read-only registers change nothing and answer SLVERR; out-of-range reads
// return zero with SLVERR. Readies depend on internal state only.
// -----------------------------------------------------------------------------
module axi_lite_regfile_sub #(
    parameter int unsigned                AXI_ADDR_WIDTH = 32'd8,
    parameter int unsigned                AXI_DATA_WIDTH = 32'd32,
    parameter int unsigned                NUM_REGS       = 32'd8,
    parameter logic [NUM_REGS-1:0]        RO_MASK        = '0,
    parameter logic [AXI_DATA_WIDTH-1:0]  RESET_VALUE    = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [AXI_ADDR_WIDTH-1:0]            aw_addr_i,
    input  logic [2:0]                           aw_prot_i,
    input  logic                                 aw_valid_i,
    output logic                                 aw_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]            w_data_i,
    input  logic [AXI_DATA_WIDTH/32'd8-1:0]      w_strb_i,
    input  logic                                 w_valid_i,
    output logic                                 w_ready_o,
    output logic [1:0]                           b_resp_o,
    output logic                                 b_valid_o,
    input  logic                                 b_ready_i,
    input  logic [AXI_ADDR_WIDTH-1:0]            ar_addr_i,
    input  logic [2:0]                           ar_prot_i,
    input  logic                                 ar_valid_i,
    output logic                                 ar_ready_o,
    output logic [AXI_DATA_WIDTH-1:0]            r_data_o,
    output logic [1:0]                           r_resp_o,
    output logic                                 r_valid_o,
    input  logic                                 r_ready_i,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0]   reg_q_o,
    output logic [NUM_REGS-1:0]                  reg_wr_o
);

    localparam int unsigned STRB = AXI_DATA_WIDTH / 32'd8;
    localparam int unsigned OFFS = $clog2(STRB);
    localparam int unsigned IDXW = AXI_ADDR_WIDTH - OFFS;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Register state
    logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs_r;
    logic [NUM_REGS-1:0]                     reg_wr_r;
    logic [IDXW-1:0]                         aw_idx_r;
    logic                                    aw_held_r;
    logic [AXI_DATA_WIDTH-1:0]               w_data_r;
    logic [STRB-1:0]                         w_strb_r;
    logic                                    w_held_r;
    logic                                    b_valid_r;
    logic [1:0]                              b_resp_r;
    logic                                    r_valid_r;
    logic [AXI_DATA_WIDTH-1:0]               r_data_r;
    logic [1:0]                              r_resp_r;

    // Combinational helpers
    logic                                    aw_ready_s;
    logic                                    w_ready_s;
    logic                                    ar_ready_s;
    logic                                    aw_hs_s;
    logic                                    w_hs_s;
    logic                                    ar_hs_s;
    logic                                    commit_s;
    logic [IDXW-1:0]                         wr_idx_s;
    logic [AXI_DATA_WIDTH-1:0]               wr_data_s;
    logic [STRB-1:0]                         wr_strb_s;
    logic [NUM_REGS-1:0]                     wr_hit_s;
    logic                                    wr_ok_s;
    logic [IDXW-1:0]                         rd_idx_s;
    logic [AXI_DATA_WIDTH-1:0]               rd_data_s;
    logic                                    rd_hit_s;
    logic                                    unused_s;

    // Protection bits and byte-offset address bits carry no meaning here.
    assign unused_s = ^{aw_prot_i, ar_prot_i, aw_addr_i, ar_addr_i};

    // A channel stays blocked once its beat is held, and both write channels
    // stay blocked while a write response is outstanding.
    assign aw_ready_s = !aw_held_r && !b_valid_r;
    assign w_ready_s  = !w_held_r && !b_valid_r;
    assign ar_ready_s = !r_valid_r;

    assign aw_hs_s  = aw_valid_i && aw_ready_s;
    assign w_hs_s   = w_valid_i && w_ready_s;
    assign ar_hs_s  = ar_valid_i && ar_ready_s;

    // Commit as soon as both halves are present, whether held or arriving now.
    assign commit_s = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);

    assign wr_idx_s  = aw_held_r ? aw_idx_r : aw_addr_i[AXI_ADDR_WIDTH-1:OFFS];
    assign wr_data_s = w_held_r ? w_data_r : w_data_i;
    assign wr_strb_s = w_held_r ? w_strb_r : w_strb_i;
    assign rd_idx_s  = ar_addr_i[AXI_ADDR_WIDTH-1:OFFS];

    // Address decode: one-hot write target (empty when out of range) and the
    // read mux, which yields zero for an out-of-range index.
    always_comb begin
        wr_hit_s  = '0;
        rd_data_s = '0;
        rd_hit_s  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit_s[i] = (wr_idx_s == IDXW'(i));
            rd_data_s   = rd_data_s | ((rd_idx_s == IDXW'(i)) ? regs_r[i] : '0);
            rd_hit_s    = rd_hit_s | (rd_idx_s == IDXW'(i));
        end
        wr_ok_s = |(wr_hit_s & ~RO_MASK);
    end

    // Write channel capture, commit, register update and B response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_r    <= {NUM_REGS{RESET_VALUE}};
            reg_wr_r  <= '0;
            aw_idx_r  <= '0;
            aw_held_r <= 1'b0;
            w_data_r  <= '0;
            w_strb_r  <= '0;
            w_held_r  <= 1'b0;
            b_valid_r <= 1'b0;
            b_resp_r  <= RESP_OKAY;
        end else begin
            reg_wr_r <= (commit_s && wr_ok_s) ? wr_hit_s : '0;
            if (commit_s) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    for (int b = 0; b < STRB; b++) begin
                        if (wr_ok_s && wr_hit_s[i] && wr_strb_s[b]) begin
                            regs_r[i][b*8 +: 8] <= wr_data_s[b*8 +: 8];
                        end
                    end
                end
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                b_valid_r <= 1'b1;
                b_resp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs_s) begin
                    aw_idx_r  <= aw_addr_i[AXI_ADDR_WIDTH-1:OFFS];
                    aw_held_r <= 1'b1;
                end
                if (w_hs_s) begin
                    w_data_r <= w_data_i;
                    w_strb_r <= w_strb_i;
                    w_held_r <= 1'b1;
                end
                if (b_valid_r && b_ready_i) begin
                    b_valid_r <= 1'b0;
                end
            end
        end
    end

    // Read channel: sample the register bank on AR handshake, which returns
    // the pre-write value when a write commits to the same register at the
    // same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_r <= 1'b0;
            r_data_r  <= '0;
            r_resp_r  <= RESP_OKAY;
        end else begin
            if (ar_hs_s) begin
                r_valid_r <= 1'b1;
                r_data_r  <= rd_data_s;
                r_resp_r  <= rd_hit_s ? RESP_OKAY : RESP_SLVERR;
            end else if (r_valid_r && r_ready_i) begin
                r_valid_r <= 1'b0;
            end
        end
    end

    assign aw_ready_o = aw_ready_s;
    assign w_ready_o  = w_ready_s;
    assign ar_ready_o = ar_ready_s;
    assign b_valid_o  = b_valid_r;
    assign b_resp_o   = b_resp_r;
    assign r_valid_o  = r_valid_r;
    assign r_data_o   = r_data_r;
    assign r_resp_o   = r_resp_r;
    assign reg_q_o    = regs_r;
    assign reg_wr_o   = reg_wr_r;

endmodule

// File: tb/tb_axi_lite_regfile_sub.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_regfile_sub
//
// Directed and randomized bench for axi_lite_regfile_sub (8 x 32-bit registers,
// register 0 read-only). Expected values come from a behavioural array model
// of the register bank updated with the access rules (byte strobes, range and
// read-only checks).
// -----------------------------------------------------------------------------
module tb_axi_lite_regfile_sub;

    localparam logic [7:0] RO = 8'h01;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   aw_addr;
    logic [2:0]   aw_prot;
    logic         aw_valid;
    logic         aw_ready;
    logic [31:0]  w_data;
    logic [3:0]   w_strb;
    logic         w_valid;
    logic         w_ready;
    logic [1:0]   b_resp;
    logic         b_valid;
    logic         b_ready;
    logic [7:0]   ar_addr;
    logic [2:0]   ar_prot;
    logic         ar_valid;
    logic         ar_ready;
    logic [31:0]  r_data;
    logic [1:0]   r_resp;
    logic         r_valid;
    logic         r_ready;
    logic [255:0] reg_q;
    logic [7:0]   reg_wr;

    int tests = 0;
    int fails = 0;
    logic [31:0] mregs [8];

    always #5 clk = ~clk;

    axi_lite_regfile_sub #(
        .AXI_ADDR_WIDTH(32'd8),
        .AXI_DATA_WIDTH(32'd32),
        .NUM_REGS(32'd8),
        .RO_MASK(RO),
        .RESET_VALUE(32'h0000_0000)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_addr_i(aw_addr), .aw_prot_i(aw_prot), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
        .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_prot_i(ar_prot), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
        .reg_q_o(reg_q), .reg_wr_o(reg_wr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dut_reg(input int i);
        return reg_q[i*32 +: 32];
    endfunction

    function automatic bit model_legal(input logic [7:0] addr);
        int idx;
        logic [7:0] ro_v;
        idx  = int'(addr) / 4;
        ro_v = RO;
        return (idx < 8) && !ro_v[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 32'h0000_0000;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) chk(tag, dut_reg(i), mregs[i]);
    endtask

    // Write with independent AW/W start delays; holds B for b_hold cycles.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_hold);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w, ok;
        int cyc = 0, idx;
        logic [1:0] exp_resp;
        while (!(aw_done && w_done) && cyc < 50) begin
            chk("b_valid_early", b_valid, 1'b0);
            if (aw_done) chk("aw_ready_held", aw_ready, 1'b0);
            if (w_done)  chk("w_ready_held", w_ready, 1'b0);
            aw_valid = !aw_done && (cyc >= aw_dly);
            aw_addr  = addr;
            w_valid  = !w_done && (cyc >= w_dly);
            w_data   = data;
            w_strb   = strb;
            hs_aw = aw_valid && aw_ready;
            hs_w  = w_valid && w_ready;
            tick();
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            cyc++;
        end
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        chk("write_timeout", aw_done && w_done, 1'b1);
        ok  = model_legal(addr);
        idx = int'(addr) / 4;
        if (ok) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mregs[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        exp_resp = ok ? 2'b00 : 2'b10;
        chk("b_valid", b_valid, 1'b1);
        chk("b_resp", b_resp, exp_resp);
        chk("reg_wr_pulse", reg_wr, ok ? (8'h01 << idx) : 8'h00);
        check_regs("reg_q_after_write");
        for (int h = 0; h < b_hold; h++) begin
            b_ready = 1'b0;
            tick();
            chk("b_valid_hold", b_valid, 1'b1);
            chk("b_resp_hold", b_resp, exp_resp);
            chk("aw_ready_bhold", aw_ready, 1'b0);
            chk("w_ready_bhold", w_ready, 1'b0);
            chk("reg_wr_single", reg_wr, 8'h00);
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk("b_valid_clear", b_valid, 1'b0);
        chk("reg_wr_clear", reg_wr, 8'h00);
        chk("aw_ready_reopen", aw_ready, 1'b1);
        chk("w_ready_reopen", w_ready, 1'b1);
    endtask

    // Read with R held for r_hold cycles.
    task automatic do_read(input logic [7:0] addr, input int r_hold);
        int idx;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        idx      = int'(addr) / 4;
        exp_data = (idx < 8) ? mregs[idx] : 32'h0000_0000;
        exp_resp = (idx < 8) ? 2'b00 : 2'b10;
        chk("ar_ready_idle", ar_ready, 1'b1);
        ar_valid = 1'b1;
        ar_addr  = addr;
        tick();
        ar_valid = 1'b0;
        chk("r_valid", r_valid, 1'b1);
        chk("r_data", r_data, exp_data);
        chk("r_resp", r_resp, exp_resp);
        for (int h = 0; h < r_hold; h++) begin
            r_ready = 1'b0;
            tick();
            chk("r_valid_hold", r_valid, 1'b1);
            chk("r_data_hold", r_data, exp_data);
            chk("r_resp_hold", r_resp, exp_resp);
            chk("ar_ready_rhold", ar_ready, 1'b0);
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk("r_valid_clear", r_valid, 1'b0);
        chk("ar_ready_reopen", ar_ready, 1'b1);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] old_v;
        rst = 1'b1;
        aw_addr = 8'h00; aw_prot = 3'b000; aw_valid = 1'b0;
        w_data = 32'h0; w_strb = 4'h0; w_valid = 1'b0; b_ready = 1'b0;
        ar_addr = 8'h00; ar_prot = 3'b000; ar_valid = 1'b0; r_ready = 1'b0;
        model_reset();

        // Reset state (during and after reset)
        #1;
        chk("rst_aw_ready", aw_ready, 1'b1);
        chk("rst_w_ready", w_ready, 1'b1);
        chk("rst_ar_ready", ar_ready, 1'b1);
        chk("rst_b_valid", b_valid, 1'b0);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_b_resp", b_resp, 2'b00);
        chk("rst_r_resp", r_resp, 2'b00);
        chk("rst_r_data", r_data, 32'h0);
        chk("rst_reg_wr", reg_wr, 8'h00);
        repeat (3) tick();
        rst = 1'b0;
        check_regs("rst_regs");
        chk("post_rst_aw_ready", aw_ready, 1'b1);

        // Same-cycle AW+W, full strobe
        do_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        // W first, AW three cycles later, partial strobe
        do_write(8'h08, 32'h1122_3344, 4'b0101, 3, 0, 0);
        // AW first
        do_write(8'h10, 32'hCAFE_F00D, 4'b1010, 0, 2, 0);
        // Out of range write and read
        do_write(8'h40, 32'h1234_5678, 4'hF, 0, 0, 0);
        do_read(8'h40, 0);
        // Read-only register
        do_write(8'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_read(8'h00, 0);
        // Backpressure on B and R for 5 cycles; ignored low address bits
        do_write(8'h17, 32'h0BAD_CAFE, 4'hF, 1, 1, 5);
        do_read(8'h15, 5);
        do_read(8'h08, 0);

        // Same-cycle read and write commit to register 3
        do_write(8'h0C, 32'hA5A5_A5A5, 4'hF, 0, 0, 0);
        old_v = mregs[3];
        aw_valid = 1'b1; aw_addr = 8'h0C;
        w_valid = 1'b1; w_data = 32'h5A5A_5A5A; w_strb = 4'hF;
        ar_valid = 1'b1; ar_addr = 8'h0C;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        mregs[3] = 32'h5A5A_5A5A;
        chk("rw_same_r_valid", r_valid, 1'b1);
        chk("rw_same_r_data_old", r_data, old_v);
        chk("rw_same_b_valid", b_valid, 1'b1);
        chk("rw_same_reg3_new", dut_reg(3), 32'h5A5A_5A5A);
        b_ready = 1'b1; r_ready = 1'b1;
        tick();
        b_ready = 1'b0; r_ready = 1'b0;
        chk("rw_same_b_clear", b_valid, 1'b0);
        chk("rw_same_r_clear", r_valid, 1'b0);
        do_read(8'h0C, 0);

        // Randomized accesses against the model
        for (int n = 0; n < 30; n++) begin
            a = 8'(($urandom_range(0, 19) * 4) + $urandom_range(0, 3));
            do_write(a, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            a = 8'(($urandom_range(0, 19) * 4) + $urandom_range(0, 3));
            do_read(a, $urandom_range(0, 2));
        end

        // Reset while a write response is pending
        aw_valid = 1'b1; aw_addr = 8'h0C;
        w_valid = 1'b1; w_data = 32'h1234_5678; w_strb = 4'hF;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("pre_rst_b_valid", b_valid, 1'b1);
        chk("pre_rst_reg3", dut_reg(3), 32'h1234_5678);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_b_valid", b_valid, 1'b0);
        chk("mid_rst_reg3", dut_reg(3), 32'h0000_0000);
        check_regs("mid_rst_regs");
        tick();
        rst = 1'b0;
        do_write(8'h1C, 32'h7777_8888, 4'hF, 0, 0, 0);
        do_read(8'h1C, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
